// File: rtl/jedro_1_mem_arb_pkg.sv
// Shared types for the jedro_1 memory arbiter.
//   resp_state_e : response FSM states (IDLE, I_RESP, D_RESP)
//   req_id_e     : requester identity, used for the round-robin last-winner
package jedro_1_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_RESP = 2'd1,
    D_RESP = 2'd2
  } resp_state_e;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/jedro_1_arb_grant.sv
// Two-requester grant logic for the jedro_1 memory arbiter.
// Ports:
//   i_req, d_req : instruction / data requests (already qualified by reset)
//   last_winner  : requester granted most recently
//   i_gnt, d_gnt : one-hot grants (both 0 when nothing requests)
// Configuration macro JEDRO_1_ARB_RR_EN: when defined, simultaneous requests
// are resolved round-robin (the requester not granted last wins); otherwise
// data has fixed priority over instruction and last_winner is ignored.
module jedro_1_arb_grant
  import jedro_1_mem_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_e last_winner,
  output logic    i_gnt,
  output logic    d_gnt
);

`ifndef JEDRO_1_ARB_RR_EN
  // Fixed priority never looks at the history input.
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
`endif

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (i_req && d_req) begin
`ifdef JEDRO_1_ARB_RR_EN
      if (last_winner == REQ_DATA) i_gnt = 1'b1;
      else                         d_gnt = 1'b1;
`else
      d_gnt = 1'b1;
`endif
    end else begin
      i_gnt = i_req;
      d_gnt = d_req;
    end
  end

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// jedro_1_mem_arbiter: shares one single-port byte-write RAM between an
// instruction-fetch port and a data port. Grants are combinational, reads
// return one cycle after grant to the requester that was granted.
// Ports:
//   clk_i, rstn_i                    : clock, synchronous active-low reset
//   i_req_i/i_addr_i                 : fetch request and address
//   i_gnt_o/i_rvalid_o/i_rdata_o     : fetch grant and read response
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i : data-port request
//   d_gnt_o/d_rvalid_o/d_rdata_o     : data grant and read response
//   m_en_o/m_we_o/m_addr_o/m_wdata_o : RAM command
//   m_rdata_i                        : RAM read data, one cycle after m_en_o
// Configuration macro JEDRO_1_ARB_RR_EN: round-robin arbitration with a
// last-winner register; undefined gives fixed data-over-instruction priority.
module jedro_1_mem_arbiter
  import jedro_1_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic                    i_gnt_o,
  output logic                    i_rvalid_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    m_en_o,
  output logic [DATA_WIDTH/8-1:0] m_we_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i
);

  resp_state_e state;
  req_id_e     last_winner;
  logic        i_gnt;
  logic        d_gnt;
  logic        i_rvalid_q;
  logic        d_rvalid_q;

  // Requests are masked during reset so nothing reaches the RAM and no
  // response can be scheduled from a grant in a reset cycle.
  jedro_1_arb_grant u_grant (
    .i_req       (i_req_i & rstn_i),
    .d_req       (d_req_i & rstn_i),
    .last_winner (last_winner),
    .i_gnt       (i_gnt),
    .d_gnt       (d_gnt)
  );

  assign i_gnt_o = i_gnt;
  assign d_gnt_o = d_gnt;

  // RAM command from the winner
  always_comb begin
    m_en_o    = i_gnt | d_gnt;
    m_addr_o  = '0;
    m_wdata_o = '0;
    m_we_o    = '0;
    if (d_gnt) begin
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
      if (d_we_i) m_we_o = d_be_i;
    end else if (i_gnt) begin
      m_addr_o = i_addr_i;
    end
  end

  // Response FSM; rvalid flags are registered alongside the state
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else if (d_gnt && !d_we_i) begin
      state      <= D_RESP;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b1;
    end else if (i_gnt) begin
      state      <= I_RESP;
      i_rvalid_q <= 1'b1;
      d_rvalid_q <= 1'b0;
    end else begin
      state      <= IDLE;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end
  end

  // A response pending when reset asserts must not escape in that cycle.
  assign i_rvalid_o = i_rvalid_q & rstn_i & (state == I_RESP);
  assign d_rvalid_o = d_rvalid_q & rstn_i & (state == D_RESP);
  assign i_rdata_o  = i_rvalid_o ? m_rdata_i : '0;
  assign d_rdata_o  = d_rvalid_o ? m_rdata_i : '0;

`ifdef JEDRO_1_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i)    last_winner <= REQ_INSTR;
    else if (d_gnt) last_winner <= REQ_DATA;
    else if (i_gnt) last_winner <= REQ_INSTR;
  end
`else
  assign last_winner = REQ_INSTR;
`endif

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed self-checking bench for jedro_1_mem_arbiter with a small
// byte-write RAM model (one-cycle read latency) attached to the m_* port.
module tb_jedro_1_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        m_en_o;
  logic [3:0]  m_we_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic [31:0] m_rdata_i;

  int passes = 0;
  int total  = 0;

`ifdef JEDRO_1_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  jedro_1_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .i_req_i    (i_req_i),
    .i_addr_i   (i_addr_i),
    .i_gnt_o    (i_gnt_o),
    .i_rvalid_o (i_rvalid_o),
    .i_rdata_o  (i_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_be_i     (d_be_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .m_en_o     (m_en_o),
    .m_we_o     (m_we_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_rdata_i  (m_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: contents loaded on the first reset cycle
  logic [31:0] mem [0:255];
  logic        loaded = 1'b0;

  always @(posedge clk_i) begin
    if (!rstn_i && !loaded) begin
      for (int w = 0; w < 256; w++) mem[w] <= 32'h0;
      mem[0]      <= 32'h1111_1111;
      mem[8'h04]  <= 32'h0050_0093;  // byte address 0x10
      mem[8'h10]  <= 32'h2222_2222;  // byte address 0x40
      loaded      <= 1'b1;
    end else if (m_en_o) begin
      for (int b = 0; b < 4; b++)
        if (m_we_o[b]) mem[m_addr_o[9:2]][8*b +: 8] <= m_wdata_o[8*b +: 8];
      m_rdata_i <= mem[m_addr_o[9:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rstn_i = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h10;
    d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0;

    // Reset state with a pending fetch request
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_i_gnt", i_gnt_o, 0);
    check("rst_d_gnt", d_gnt_o, 0);
    check("rst_m_en", m_en_o, 0);
    check("rst_m_we", m_we_o, 0);
    check("rst_i_rvalid", i_rvalid_o, 0);
    check("rst_d_rvalid", d_rvalid_o, 0);
    check("rst_i_rdata", i_rdata_o, 0);
    check("rst_d_rdata", d_rdata_o, 0);

    // Instr-only read at 0x10 in the first cycle after release
    @(negedge clk_i);
    rstn_i = 1'b1; i_req_i = 1'b1; i_addr_i = 32'h10;
    #1;
    check("f_i_gnt", i_gnt_o, 1);
    check("f_d_gnt", d_gnt_o, 0);
    check("f_m_en", m_en_o, 1);
    check("f_m_addr", m_addr_o, 32'h10);
    check("f_m_we", m_we_o, 0);
    @(negedge clk_i);
    i_req_i = 1'b0;
    #1;
    check("f_i_rvalid", i_rvalid_o, 1);
    check("f_i_rdata", i_rdata_o, 32'h0050_0093);
    check("f_d_rvalid", d_rvalid_o, 0);
    check("f_d_rdata", d_rdata_o, 0);
    check("f_m_en_idle", m_en_o, 0);
    @(negedge clk_i);
    #1;
    check("f_i_rvalid_done", i_rvalid_o, 0);

    // Simultaneous instr read 0x0 and data read 0x40
    i_req_i = 1'b1; i_addr_i = 32'h0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40;
    #1;
    check("sim_d_gnt", d_gnt_o, 1);
    check("sim_i_gnt", i_gnt_o, 0);
    check("sim_m_addr", m_addr_o, 32'h40);
    @(negedge clk_i);
    d_req_i = 1'b0;
    #1;
    check("sim_i_gnt_n1", i_gnt_o, 1);
    check("sim_m_addr_n1", m_addr_o, 32'h0);
    check("sim_d_rvalid_n1", d_rvalid_o, 1);
    check("sim_d_rdata_n1", d_rdata_o, 32'h2222_2222);
    check("sim_i_rvalid_n1", i_rvalid_o, 0);
    @(negedge clk_i);
    i_req_i = 1'b0;
    #1;
    check("sim_i_rvalid_n2", i_rvalid_o, 1);
    check("sim_i_rdata_n2", i_rdata_o, 32'h1111_1111);
    check("sim_d_rvalid_n2", d_rvalid_o, 0);
    check("sim_d_rdata_n2", d_rdata_o, 0);

    // Byte-enabled write to 0x80 then read back
    @(negedge clk_i);
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011;
    d_addr_i = 32'h80; d_wdata_i = 32'hDEAD_BEEF;
    #1;
    check("wr_d_gnt", d_gnt_o, 1);
    check("wr_m_we", m_we_o, 4'b0011);
    check("wr_m_wdata", m_wdata_o, 32'hDEAD_BEEF);
    check("wr_m_addr", m_addr_o, 32'h80);
    @(negedge clk_i);
    d_we_i = 1'b0;
    #1;
    check("wr_no_rvalid", d_rvalid_o, 0);
    check("rd_d_gnt", d_gnt_o, 1);
    check("rd_m_we", m_we_o, 0);
    @(negedge clk_i);
    d_req_i = 1'b0;
    #1;
    check("rd_d_rvalid", d_rvalid_o, 1);
    check("rd_d_rdata", d_rdata_o, 32'h0000_BEEF);

    // Reset asserted in the cycle after an instr grant
    @(negedge clk_i);
    i_req_i = 1'b1; i_addr_i = 32'h10;
    #1;
    check("rg_i_gnt", i_gnt_o, 1);
    @(negedge clk_i);
    rstn_i = 1'b0; i_req_i = 1'b0;
    d_req_i = 1'b1; d_addr_i = 32'h40;
    #1;
    check("rg_i_rvalid", i_rvalid_o, 0);
    check("rg_i_rdata", i_rdata_o, 0);
    check("rg_d_gnt", d_gnt_o, 0);
    check("rg_m_en", m_en_o, 0);
    @(negedge clk_i);
    #1;
    check("rg_i_rvalid2", i_rvalid_o, 0);
    check("rg_d_rvalid2", d_rvalid_o, 0);
    check("rg_m_en2", m_en_o, 0);

    // Both requesters held for 6 cycles straight after release
    @(negedge clk_i);
    rstn_i = 1'b1;
    i_req_i = 1'b1; i_addr_i = 32'h10;
    d_req_i = 1'b1; d_addr_i = 32'h40;
    for (int k = 0; k < 6; k++) begin
      logic exp_d;
      logic prev_d;
      exp_d  = RR ? (k % 2 == 0) : 1'b1;
      prev_d = RR ? (k % 2 == 1) : 1'b1;
      #1;
      check($sformatf("both_d_gnt_%0d", k), d_gnt_o, exp_d);
      check($sformatf("both_i_gnt_%0d", k), i_gnt_o, !exp_d);
      if (k > 0) begin
        check($sformatf("both_d_rvalid_%0d", k), d_rvalid_o, prev_d);
        check($sformatf("both_i_rvalid_%0d", k), i_rvalid_o, !prev_d);
        check($sformatf("both_rdata_%0d", k), prev_d ? d_rdata_o : i_rdata_o,
              prev_d ? 32'h2222_2222 : 32'h0050_0093);
      end
      @(negedge clk_i);
    end
    i_req_i = 1'b0; d_req_i = 1'b0;
    #1;
    check("end_m_en", m_en_o, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
